chunked_addsub: RTL and testbench



---
 rtl/chunked_addsub_pkg.sv | 21 ++
 rtl/chunked_addsub_ripple.sv | 29 ++
 rtl/chunked_addsub.sv | 117 +++++++++++
 tb/tb_chunked_addsub.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chunked_addsub_pkg.sv
// Shared types and helpers for the chunked adder/subtractor.
// State encoding is fixed so that the encoding is visible in waveforms.
package chunked_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2. Written as a bounded loop so that it folds at elaboration.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/chunked_addsub_ripple.sv
// Combinational CHUNK-bit ripple adder.
// Exposes the carry into its MSB so that the caller can derive signed overflow.
module chunk_ripple_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_top
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[CHUNK];
  assign c_top = c[CHUNK-1];

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits per clock,
// with a registered carry between beats and valid/ready on both sides.
//
// state | meaning
// IDLE  | in_ready=1, waiting for operands
// RUN   | one chunk added per cycle, carry held in a register
// DONE  | out_valid=1, result held until out_ready
module chunked_addsub
  import chunked_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int N      = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;
  localparam int BEAT_W = (N > 1) ? clog2(N) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N - 1);

  if (CHUNK < 1) begin : g_bad_chunk
    $error("chunked_addsub: CHUNK must be at least 1");
  end else if ((WIDTH % CHUNK) != 0) begin : g_bad_divide
    $error("chunked_addsub: CHUNK must divide WIDTH");
  end

  state_t            state;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  acc_next;
  logic [BEAT_W-1:0] beat;
  logic              carry;

  logic [CHUNK-1:0]       s_chunk;
  logic                   cout_chunk;
  logic                   ctop_chunk;
  logic [WIDTH+CHUNK-1:0] acc_shift;

  // Operands shift right one chunk per beat, so the active chunk is always
  // the low CHUNK bits; the accumulator fills from the top in the same way.
  chunk_ripple_adder #(.CHUNK(CHUNK)) u_adder (
    .a     (a_reg[CHUNK-1:0]),
    .b     (b_reg[CHUNK-1:0]),
    .cin   (carry),
    .s     (s_chunk),
    .cout  (cout_chunk),
    .c_top (ctop_chunk)
  );

  assign acc_shift = {s_chunk, acc};
  assign acc_next  = acc_shift[WIDTH+CHUNK-1:CHUNK];
  assign in_ready  = (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      beat      <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= x;
            b_reg <= y ^ {WIDTH{sub}};
            carry <= c_in ^ sub;
            acc   <= '0;
            beat  <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_reg <= a_reg >> CHUNK;
          b_reg <= b_reg >> CHUNK;
          acc   <= acc_next;
          carry <= cout_chunk;
          if (beat == LAST_BEAT) begin
            sum       <= acc_next;
            c_out     <= cout_chunk;
            overflow  <= ctop_chunk ^ cout_chunk;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_addsub.sv
// Self-checking bench for chunked_addsub across four WIDTH/CHUNK configurations,
// compared against a signed/unsigned arithmetic reference model.
module tb_chunked_addsub;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int ws[4] = '{16, 16, 16, 12};
  int cs[4] = '{4, 1, 16, 3};

  logic        in_valid_i[4];
  logic        out_ready_i[4];
  logic        c_in_i[4];
  logic        sub_i[4];
  logic [15:0] x_i[4];
  logic [15:0] y_i[4];

  logic        in_ready_o[4];
  logic        out_valid_o[4];
  logic [15:0] sum_o[4];
  logic        c_out_o[4];
  logic        ovf_o[4];

  logic        rdy0, rdy1, rdy2, rdy3;
  logic        ov0, ov1, ov2, ov3;
  logic        co0, co1, co2, co3;
  logic        of0, of1, of2, of3;
  logic [15:0] sum0, sum1, sum2;
  logic [11:0] sum3;

  chunked_addsub #(.WIDTH(16), .CHUNK(4)) u_w16c4 (
    .clk(clk), .reset(reset), .in_valid(in_valid_i[0]), .in_ready(rdy0),
    .x(x_i[0]), .y(y_i[0]), .c_in(c_in_i[0]), .sub(sub_i[0]),
    .out_valid(ov0), .out_ready(out_ready_i[0]), .sum(sum0), .c_out(co0), .overflow(of0));

  chunked_addsub #(.WIDTH(16), .CHUNK(1)) u_w16c1 (
    .clk(clk), .reset(reset), .in_valid(in_valid_i[1]), .in_ready(rdy1),
    .x(x_i[1]), .y(y_i[1]), .c_in(c_in_i[1]), .sub(sub_i[1]),
    .out_valid(ov1), .out_ready(out_ready_i[1]), .sum(sum1), .c_out(co1), .overflow(of1));

  chunked_addsub #(.WIDTH(16), .CHUNK(16)) u_w16c16 (
    .clk(clk), .reset(reset), .in_valid(in_valid_i[2]), .in_ready(rdy2),
    .x(x_i[2]), .y(y_i[2]), .c_in(c_in_i[2]), .sub(sub_i[2]),
    .out_valid(ov2), .out_ready(out_ready_i[2]), .sum(sum2), .c_out(co2), .overflow(of2));

  chunked_addsub #(.WIDTH(12), .CHUNK(3)) u_w12c3 (
    .clk(clk), .reset(reset), .in_valid(in_valid_i[3]), .in_ready(rdy3),
    .x(x_i[3][11:0]), .y(y_i[3][11:0]), .c_in(c_in_i[3]), .sub(sub_i[3]),
    .out_valid(ov3), .out_ready(out_ready_i[3]), .sum(sum3), .c_out(co3), .overflow(of3));

  always_comb begin
    in_ready_o[0]  = rdy0; in_ready_o[1]  = rdy1; in_ready_o[2]  = rdy2; in_ready_o[3]  = rdy3;
    out_valid_o[0] = ov0;  out_valid_o[1] = ov1;  out_valid_o[2] = ov2;  out_valid_o[3] = ov3;
    c_out_o[0]     = co0;  c_out_o[1]     = co1;  c_out_o[2]     = co2;  c_out_o[3]     = co3;
    ovf_o[0]       = of0;  ovf_o[1]       = of1;  ovf_o[2]       = of2;  ovf_o[3]       = of3;
    sum_o[0] = sum0;
    sum_o[1] = sum1;
    sum_o[2] = sum2;
    sum_o[3] = {4'h0, sum3};
  end

  // Reference: unsigned result/carry and signed range check on the exact value.
  function automatic void ref_model(input int w, input logic [15:0] xa, input logic [15:0] ya,
                                    input logic ci, input logic sb,
                                    output logic [15:0] es, output logic ec, output logic eo);
    longint mask, ux, uy, full, sx, sy, sres, lo, hi, cil;
    mask = (longint'(1) << w) - 1;
    ux   = longint'(xa) & mask;
    uy   = longint'(ya) & mask;
    cil  = ci ? 1 : 0;
    sx   = (ux >= (longint'(1) << (w - 1))) ? ux - (longint'(1) << w) : ux;
    sy   = (uy >= (longint'(1) << (w - 1))) ? uy - (longint'(1) << w) : uy;
    if (!sb) begin
      full = ux + uy + cil;
      ec   = (full >= (longint'(1) << w));
      sres = sx + sy + cil;
    end else begin
      full = ux - uy - cil;
      ec   = (ux >= uy + cil);
      sres = sx - sy - cil;
    end
    es = 16'(full & mask);
    lo = -(longint'(1) << (w - 1));
    hi = (longint'(1) << (w - 1)) - 1;
    eo = (sres < lo) || (sres > hi);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int idx, input logic [15:0] xa, input logic [15:0] ya,
                        input logic ci, input logic sb,
                        input logic [15:0] es, input logic ec, input logic eo,
                        input int stall, input string tag);
    int n, lat;
    n = ws[idx] / cs[idx];
    lat = 0;
    while (!in_ready_o[idx] && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (in_ready_o[idx] !== 1'b1) begin
      failures++;
      $display("FAIL %s idx%0d in_ready got %b exp 1", tag, idx, in_ready_o[idx]);
    end
    x_i[idx] = xa; y_i[idx] = ya; c_in_i[idx] = ci; sub_i[idx] = sb;
    in_valid_i[idx] = 1'b1;
    tick();
    in_valid_i[idx] = 1'b0;
    x_i[idx] = 16'($urandom); y_i[idx] = 16'($urandom);
    c_in_i[idx] = 1'($urandom); sub_i[idx] = 1'($urandom);
    lat = 0;
    while (!out_valid_o[idx] && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== n) begin
      failures++;
      $display("FAIL %s idx%0d latency got %0d exp %0d", tag, idx, lat, n);
    end
    checks++;
    if (sum_o[idx] !== es) begin
      failures++;
      $display("FAIL %s idx%0d sum got %h exp %h", tag, idx, sum_o[idx], es);
    end
    checks++;
    if (c_out_o[idx] !== ec) begin
      failures++;
      $display("FAIL %s idx%0d c_out got %b exp %b", tag, idx, c_out_o[idx], ec);
    end
    checks++;
    if (ovf_o[idx] !== eo) begin
      failures++;
      $display("FAIL %s idx%0d overflow got %b exp %b", tag, idx, ovf_o[idx], eo);
    end
    for (int i = 0; i < stall; i++) begin
      in_valid_i[idx] = 1'($urandom);
      tick();
      checks++;
      if (out_valid_o[idx] !== 1'b1 || sum_o[idx] !== es || in_ready_o[idx] !== 1'b0) begin
        failures++;
        $display("FAIL %s idx%0d hold got v=%b s=%h r=%b exp v=1 s=%h r=0",
                 tag, idx, out_valid_o[idx], sum_o[idx], in_ready_o[idx], es);
      end
    end
    in_valid_i[idx] = 1'b0;
    out_ready_i[idx] = 1'b1;
    tick();
    out_ready_i[idx] = 1'b0;
    checks++;
    if (out_valid_o[idx] !== 1'b0 || in_ready_o[idx] !== 1'b1) begin
      failures++;
      $display("FAIL %s idx%0d handshake got v=%b r=%b exp v=0 r=1",
               tag, idx, out_valid_o[idx], in_ready_o[idx]);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid_i[i] = 1'b0; out_ready_i[i] = 1'b0; c_in_i[i] = 1'b0;
      sub_i[i] = 1'b0; x_i[i] = '0; y_i[i] = '0;
    end
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_ready_o[i] !== 1'b1 || out_valid_o[i] !== 1'b0 || sum_o[i] !== 16'h0 ||
          c_out_o[i] !== 1'b0 || ovf_o[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset idx%0d got r=%b v=%b s=%h c=%b o=%b exp r=1 v=0 s=0 c=0 o=0",
                 i, in_ready_o[i], out_valid_o[i], sum_o[i], c_out_o[i], ovf_o[i]);
      end
    end
  endtask

  task automatic test_directed();
    run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0, "add_ovf");
    run_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1, "sub_borrow");
    run_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0, "sub_ovf");
    run_op(0, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 2, "carry_chain");
  endtask

  task automatic test_backpressure();
    int lat;
    x_i[0] = 16'h1357; y_i[0] = 16'h0246; c_in_i[0] = 1'b0; sub_i[0] = 1'b0;
    in_valid_i[0] = 1'b1;
    tick();
    lat = 0;
    while (!out_valid_o[0] && lat < 40) begin
      x_i[0] = 16'($urandom); y_i[0] = 16'($urandom);
      tick();
      lat++;
    end
    checks++;
    if (lat !== 4 || sum_o[0] !== 16'h159D) begin
      failures++;
      $display("FAIL bp_first got lat=%0d s=%h exp lat=4 s=159d", lat, sum_o[0]);
    end
    for (int i = 0; i < 10; i++) begin
      x_i[0] = 16'($urandom); y_i[0] = 16'($urandom); c_in_i[0] = 1'($urandom);
      in_valid_i[0] = 1'b1;
      out_ready_i[0] = 1'b0;
      tick();
      checks++;
      if (out_valid_o[0] !== 1'b1 || sum_o[0] !== 16'h159D || c_out_o[0] !== 1'b0 ||
          ovf_o[0] !== 1'b0 || in_ready_o[0] !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc%0d got v=%b s=%h c=%b o=%b r=%b exp v=1 s=159d c=0 o=0 r=0",
                 i, out_valid_o[0], sum_o[0], c_out_o[0], ovf_o[0], in_ready_o[0]);
      end
    end
    x_i[0] = 16'h00FF; y_i[0] = 16'h0F01; c_in_i[0] = 1'b0; sub_i[0] = 1'b0;
    out_ready_i[0] = 1'b1;
    tick();
    out_ready_i[0] = 1'b0;
    checks++;
    if (out_valid_o[0] !== 1'b0 || in_ready_o[0] !== 1'b1) begin
      failures++;
      $display("FAIL bp_release got v=%b r=%b exp v=0 r=1", out_valid_o[0], in_ready_o[0]);
    end
    tick();
    in_valid_i[0] = 1'b0;
    checks++;
    if (in_ready_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL bp_accept got r=%b exp 0", in_ready_o[0]);
    end
    lat = 0;
    while (!out_valid_o[0] && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== 4 || sum_o[0] !== 16'h1000 || c_out_o[0] !== 1'b0 || ovf_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL bp_second got lat=%0d s=%h c=%b o=%b exp lat=4 s=1000 c=0 o=0",
               lat, sum_o[0], c_out_o[0], ovf_o[0]);
    end
    out_ready_i[0] = 1'b1;
    tick();
    out_ready_i[0] = 1'b0;
  endtask

  task automatic test_abort();
    x_i[0] = 16'hABCD; y_i[0] = 16'h1111; c_in_i[0] = 1'b1; sub_i[0] = 1'b0;
    in_valid_i[0] = 1'b1;
    tick();
    in_valid_i[0] = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready_o[0] !== 1'b1 || out_valid_o[0] !== 1'b0 || sum_o[0] !== 16'h0 ||
        c_out_o[0] !== 1'b0 || ovf_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset got r=%b v=%b s=%h c=%b o=%b exp r=1 v=0 s=0 c=0 o=0",
               in_ready_o[0], out_valid_o[0], sum_o[0], c_out_o[0], ovf_o[0]);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (out_valid_o[0] !== 1'b0 || in_ready_o[0] !== 1'b1) begin
        failures++;
        $display("FAIL abort_quiet cyc%0d got v=%b r=%b exp v=0 r=1",
                 i, out_valid_o[0], in_ready_o[0]);
      end
    end
    run_op(0, 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 0, "after_abort");
  endtask

  task automatic test_random(input int idx, input int count);
    logic [15:0] xa, ya, es, mask;
    logic ci, sb, ec, eo;
    int sel;
    mask = 16'((32'd1 << ws[idx]) - 1);
    for (int i = 0; i < count; i++) begin
      sel = int'($urandom_range(0, 7));
      xa = 16'($urandom) & mask;
      ya = 16'($urandom) & mask;
      if (sel == 0) xa = mask;
      if (sel == 1) ya = mask;
      if (sel == 2) xa = mask >> 1;
      ci = 1'($urandom);
      sb = 1'($urandom);
      ref_model(ws[idx], xa, ya, ci, sb, es, ec, eo);
      run_op(idx, xa, ya, ci, sb, es, ec, eo, int'($urandom_range(0, 2)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_abort();
    test_random(0, 200);
    test_random(1, 1000);
    test_random(2, 1000);
    test_random(3, 1000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
